// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: PC generator, I-cache request/response and issue handshakes.
// The fetch stage uses the master view; the surrounding environment uses slave.
interface instr_fetch_if #(
  parameter int XLEN   = 32,
  parameter int ILEN   = 32,
  parameter int LINE_W = 128
);
  logic              flush_i;
  logic [XLEN-1:0]   pc_i;
  logic              fetch_ready_o;
  logic [XLEN-1:0]   addr_o;
  logic              addr_valid_o;
  logic              addr_ready_i;
  logic [LINE_W-1:0] data_i;
  logic              data_valid_i;
  logic              data_ready_o;
  logic              issue_ready_i;
  logic              issue_valid_o;
  logic [ILEN-1:0]   instruction_o;
  logic [XLEN-1:0]   pc_o;

  modport master (
    input  flush_i, pc_i, addr_ready_i, data_i, data_valid_i, issue_ready_i,
    output fetch_ready_o, addr_o, addr_valid_o, data_ready_o,
           issue_valid_o, instruction_o, pc_o
  );

  modport slave (
    output flush_i, pc_i, addr_ready_i, data_i, data_valid_i, issue_ready_i,
    input  fetch_ready_o, addr_o, addr_valid_o, data_ready_o,
           issue_valid_o, instruction_o, pc_o
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: one outstanding I-cache request at a time, responses
// buffered with their PCs in an in-order FIFO feeding issue. Requires LINE_W > ILEN.
module instr_fetch_stage #(
  parameter int XLEN   = 32,
  parameter int ILEN   = 32,
  parameter int LINE_W = 128,
  parameter int DEPTH  = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  instr_fetch_if.master  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OFF_W = $clog2(ILEN / 8);
  localparam int SEL_W = $clog2(LINE_W / ILEN);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {S_REQ, S_WAIT} state_e;

  state_e            state_q, state_d;
  logic              discard_q, discard_d;
  logic [XLEN-1:0]   req_pc_q, req_pc_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [ILEN-1:0]   instr_mem_q [DEPTH];
  logic [XLEN-1:0]   pc_mem_q    [DEPTH];

  logic              has_entry, addr_valid, data_ready, req_fire, push, pop;
  logic [SEL_W-1:0]  word_sel;
  logic [ILEN-1:0]   resp_word;

  // Everything visible to neighbours is forced low while reset is asserted.
  always_comb begin
    has_entry  = !rst_i && (count_q != '0);
    addr_valid = !rst_i && (state_q == S_REQ) && (count_q < FULL_CNT) && !bus.flush_i;
    data_ready = !rst_i && (state_q == S_WAIT);
    req_fire   = addr_valid && bus.addr_ready_i;
    word_sel   = req_pc_q[OFF_W +: SEL_W];
    resp_word  = bus.data_i[word_sel*ILEN +: ILEN];
    push       = data_ready && bus.data_valid_i && !discard_q && !bus.flush_i;
    pop        = has_entry && bus.issue_ready_i && !bus.flush_i;
  end

  assign bus.addr_valid_o  = addr_valid;
  assign bus.addr_o        = {bus.pc_i[XLEN-1:OFF_W], {OFF_W{1'b0}}};
  assign bus.fetch_ready_o = req_fire;
  assign bus.data_ready_o  = data_ready;
  assign bus.issue_valid_o = has_entry;
  assign bus.instruction_o = has_entry ? instr_mem_q[rd_ptr_q] : '0;
  assign bus.pc_o          = has_entry ? pc_mem_q[rd_ptr_q]    : '0;

  // A flush while waiting leaves the response in flight; discard marks it for dropping.
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    req_pc_d  = req_pc_q;
    case (state_q)
      S_REQ: begin
        if (req_fire) begin
          state_d  = S_WAIT;
          req_pc_d = bus.pc_i;
        end
      end
      S_WAIT: begin
        if (bus.data_valid_i) begin
          state_d   = S_REQ;
          discard_d = 1'b0;
        end else if (bus.flush_i) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_REQ;
      discard_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      if (bus.flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    req_pc_q <= req_pc_d;
    if (push) begin
      instr_mem_q[wr_ptr_q] <= resp_word;
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
    end
  end
endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage with a behavioural I-cache whose line words
// encode their own address, so every issued instruction can be predicted from its PC.
module tb_instr_fetch_stage;
  localparam int XLEN = 32, ILEN = 32, LINE_W = 128, DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if #(.XLEN(XLEN), .ILEN(ILEN), .LINE_W(LINE_W)) bus ();

  instr_fetch_stage #(.XLEN(XLEN), .ILEN(ILEN), .LINE_W(LINE_W), .DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  int checks = 0, errors = 0;
  int cyc = 0, fires = 0, pops = 0, cache_lat = 1;
  logic mon_en = 1'b0, pc_auto = 1'b0;
  logic [31:0] exp_pc = '0;
  logic s_av, s_fr, s_dr, s_dv, s_iv;
  logic [31:0] s_addr, s_instr, s_pco;

  function automatic logic [31:0] instr_of(input logic [31:0] p);
    return {~p[15:0], p[15:0]};
  endfunction

  function automatic logic [LINE_W-1:0] mk_line(input logic [31:0] a);
    logic [31:0] base;
    mk_line = '0;
    base = {a[31:4], 4'b0000};
    for (int j = 0; j < 4; j++) mk_line[32*j +: 32] = instr_of(base + 32'(4*j));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: sample at negedge, check the issue stream, then drive after posedge.
  task automatic cycle();
    @(negedge clk);
    s_av = bus.addr_valid_o;  s_fr = bus.fetch_ready_o; s_dr = bus.data_ready_o;
    s_dv = bus.data_valid_i;  s_iv = bus.issue_valid_o; s_addr = bus.addr_o;
    s_instr = bus.instruction_o; s_pco = bus.pc_o;
    cyc++;
    if (s_fr) fires++;
    if (mon_en && !bus.flush_i && s_iv) begin
      chk("head_pc", s_pco, exp_pc);
      chk("head_instr", s_instr, instr_of(exp_pc));
      if (bus.issue_ready_i) begin
        exp_pc = exp_pc + 4;
        pops++;
      end
    end
    @(posedge clk);
    #1;
    if (pc_auto && s_fr) bus.pc_i = bus.pc_i + 4;
  endtask

  initial begin : cache_model
    logic pend, fired, took, rst_s;
    int lat;
    logic [31:0] raddr;
    pend = 1'b0; lat = 0; raddr = '0;
    bus.data_valid_i = 1'b0;
    bus.data_i = '0;
    forever begin
      @(negedge clk);
      fired = bus.fetch_ready_o;
      took  = bus.data_valid_i && bus.data_ready_o;
      rst_s = rst;
      if (fired) raddr = bus.addr_o;
      @(posedge clk);
      #1;
      if (rst_s) begin
        pend = 1'b0;
        bus.data_valid_i = 1'b0;
      end else begin
        if (took) begin
          pend = 1'b0;
          bus.data_valid_i = 1'b0;
        end
        if (fired) begin
          pend = 1'b1;
          lat = cache_lat;
        end
        if (pend && !bus.data_valid_i) begin
          if (lat <= 1) begin
            bus.data_valid_i = 1'b1;
            bus.data_i = mk_line(raddr);
          end else begin
            lat--;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t vecs [8];
    int n, last, f0;
    logic [31:0] held;

    bus.flush_i = 1'b0; bus.pc_i = '0; bus.addr_ready_i = 1'b0; bus.issue_ready_i = 1'b0;

    vecs[0] = '{32'h0000_0104, 32'h0000_0104, 32'h0000_0104, 32'hFEFB_0104};
    vecs[1] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0100, 32'hFEFF_0100};
    vecs[2] = '{32'h0000_0108, 32'h0000_0108, 32'h0000_0108, 32'hFEF7_0108};
    vecs[3] = '{32'h0000_010C, 32'h0000_010C, 32'h0000_010C, 32'hFEF3_010C};
    vecs[4] = '{32'h0000_2000, 32'h0000_2000, 32'h0000_2000, 32'hDFFF_2000};
    vecs[5] = '{32'h0000_3FFC, 32'h0000_3FFC, 32'h0000_3FFC, 32'hC003_3FFC};
    vecs[6] = '{32'h0000_1006, 32'h0000_1004, 32'h0000_1006, 32'hEFFB_1004};
    vecs[7] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'h0007_FFF8};

    // Reset
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("rst_addr_valid", s_av, 0);
      chk("rst_fetch_ready", s_fr, 0);
      chk("rst_data_ready", s_dr, 0);
      chk("rst_issue_valid", s_iv, 0);
      chk("rst_instruction", s_instr, 0);
      chk("rst_pc_o", s_pco, 0);
    end
    rst = 1'b0;
    cycle();
    chk("post_rst_addr_valid", s_av, 1);
    chk("post_rst_addr", s_addr, 0);
    chk("post_rst_issue_valid", s_iv, 0);

    // Word select and first-transaction latency
    for (int v = 0; v < 8; v++) begin
      bus.pc_i = vecs[v].pc;
      bus.addr_ready_i = 1'b1;
      n = 0;
      do begin cycle(); n++; end while (!s_fr && n < 10);
      chk("ws_fire", s_fr, 1);
      chk("ws_addr", s_addr, vecs[v].exp_addr);
      bus.addr_ready_i = 1'b0;
      n = 0;
      do begin cycle(); n++; end while (!s_iv && n < 10);
      chk("ws_latency", n, 2);
      chk("ws_instr", s_instr, vecs[v].exp_instr);
      chk("ws_pc", s_pco, vecs[v].exp_pc);
      bus.issue_ready_i = 1'b1;
      cycle();
      bus.issue_ready_i = 1'b0;
      cycle();
      chk("ws_popped", s_iv, 0);
    end

    // Streaming from PC 0 with a 1-cycle cache
    bus.pc_i = '0; exp_pc = '0; mon_en = 1'b1; pc_auto = 1'b1; pops = 0;
    bus.issue_ready_i = 1'b1; bus.addr_ready_i = 1'b1;
    last = -1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (s_fr) begin
        if (last >= 0) chk("stream_fire_gap", cyc - last, 2);
        last = cyc;
      end
    end
    chk("stream_pops", pops, 5);
    bus.addr_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    chk("stream_drained", s_iv, 0);
    chk("stream_no_loss", exp_pc, bus.pc_i);

    // Backpressure on issue
    bus.issue_ready_i = 1'b0; bus.addr_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    bus.issue_ready_i = 1'b1;
    for (int i = 0; i < 7; i++) cycle();
    bus.issue_ready_i = 1'b0;
    held = exp_pc;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("bp_hold_valid", s_iv, 1);
      chk("bp_hold_pc", s_pco, held);
      chk("bp_hold_instr", s_instr, instr_of(held));
    end
    bus.issue_ready_i = 1'b1; bus.addr_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    chk("bp_drained", s_iv, 0);
    chk("bp_no_loss", exp_pc, bus.pc_i);

    // Full FIFO
    bus.issue_ready_i = 1'b0; bus.addr_ready_i = 1'b1;
    f0 = fires;
    for (int i = 0; i < 24; i++) cycle();
    chk("full_fetches", fires - f0, 8);
    chk("full_no_req", s_av, 0);
    chk("full_valid", s_iv, 1);
    bus.issue_ready_i = 1'b1;
    cycle();
    bus.issue_ready_i = 1'b0;
    f0 = fires;
    for (int i = 0; i < 8; i++) cycle();
    chk("full_one_refill", fires - f0, 1);
    chk("full_again_no_req", s_av, 0);
    bus.issue_ready_i = 1'b1; bus.addr_ready_i = 1'b0;
    for (int i = 0; i < 12; i++) cycle();
    chk("full_drained", s_iv, 0);
    chk("full_no_loss", exp_pc, bus.pc_i);

    // Flush in WAIT with 3 entries buffered and a slow response in flight
    bus.issue_ready_i = 1'b0; bus.addr_ready_i = 1'b1; cache_lat = 3;
    f0 = fires; n = 0;
    while ((fires - f0) < 4 && n < 40) begin cycle(); n++; end
    chk("fl_fires", fires - f0, 4);
    pc_auto = 1'b0;
    bus.pc_i = 32'h0000_8000;
    bus.flush_i = 1'b1;
    cycle();
    chk("fl_cycle_addr_valid", s_av, 0);
    chk("fl_cycle_fetch_ready", s_fr, 0);
    chk("fl_cycle_had_entries", s_iv, 1);
    bus.flush_i = 1'b0;
    exp_pc = 32'h0000_8000;
    cycle();
    chk("fl_emptied", s_iv, 0);
    n = 0;
    while (!s_dv && n < 10) begin cycle(); n++; end
    chk("fl_late_resp_seen", s_dv, 1);
    chk("fl_late_ready", s_dr, 1);
    chk("fl_late_not_issued", s_iv, 0);
    cycle();
    chk("fl_next_fire", s_fr, 1);
    chk("fl_next_addr", s_addr, 32'h0000_8000);
    chk("fl_dropped", s_iv, 0);
    bus.addr_ready_i = 1'b0;
    n = 0;
    while (!s_iv && n < 10) begin cycle(); n++; end
    chk("fl_new_pc", s_pco, 32'h0000_8000);
    chk("fl_new_instr", s_instr, 32'h7FFF_8000);
    bus.issue_ready_i = 1'b1;
    cycle();
    bus.issue_ready_i = 1'b0;
    cycle();
    chk("fl_single_entry", s_iv, 0);

    // Flush while requesting suppresses the request
    bus.addr_ready_i = 1'b1;
    bus.flush_i = 1'b1;
    cycle();
    chk("fl_req_addr_valid", s_av, 0);
    chk("fl_req_fetch_ready", s_fr, 0);
    bus.flush_i = 1'b0;
    bus.addr_ready_i = 1'b0;
    cycle();
    chk("fl_req_resumes", s_av, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
